servisia_sram_ctrl: RTL

//   Parametrised controller for external asynchronous SRAM. Sits between the
//   SoC's valid/ready memory port and the board SRAM pins.

---
 rtl/servisia_sram_ctrl_pkg.sv | 21 ++
 rtl/servisia_sram_ctrl_cnt.sv | 34 +++
 rtl/servisia_sram_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/servisia_sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// State encoding, counter widths and the byte-lane helper live here.
package servisia_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ACC   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_ACC   = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    // Wait states are legal 0..15, turnaround cycles 0..7.
    localparam int WAIT_W = 4;
    localparam int TURN_W = 3;

    function automatic int byte_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/servisia_sram_ctrl_cnt.sv
// Loadable down counter with zero flag; used for wait states and turnaround.
module servisia_sram_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/servisia_sram_ctrl.sv
// Valid/ready to asynchronous SRAM bridge with wait states and bus turnaround.
// Every pin strobe is registered; next values are derived from the next state.
module servisia_sram_ctrl
    import servisia_sram_ctrl_pkg::*;
#(
    parameter int  AW          = 16,
    parameter int  DW          = 8,
    parameter int  WAIT_CYCLES = 0,
    parameter int  TURN_CYCLES = 1,
    localparam int BW          = byte_lanes(DW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [BW-1:0] req_be_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          busy_o,
    output logic          sram_cs_no,
    output logic          sram_we_no,
    output logic          sram_oe_no,
    output logic [BW-1:0] sram_be_no,
    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe_o,
    input  logic [DW-1:0] sram_dq_i,
    output logic [2:0]    dbg_state_o
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);
    localparam logic [TURN_W-1:0] TURN_LD = TURN_W'(TURN_CYCLES);

    state_e        state_q, state_d;
    logic          last_we_q, last_we_d;
    logic          cs_n_q, cs_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, dq_oe_q, dq_oe_d;
    logic [BW-1:0] be_n_q, be_n_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dq_q, dq_d, rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          wait_load, wait_dec, wait_zero;
    logic          turn_load, turn_dec, turn_zero;
    logic          accept, start_rd, start_wr;

    // Handshake: a request transfers on a cycle where req_valid_i && req_ready_o.
    // Ready may depend on req_we_i so same-direction requests skip turnaround.
    assign req_ready_o = (state_q == ST_IDLE) && (turn_zero || (req_we_i == last_we_q));
    assign accept      = req_valid_i && req_ready_o;
    assign start_rd    = accept && !req_we_i;
    assign start_wr    = accept && req_we_i && (|req_be_i);

    servisia_sram_ctrl_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wait_load),
        .load_val_i (WAIT_LD),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

    servisia_sram_ctrl_cnt #(.W(TURN_W)) u_turn_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (turn_load),
        .load_val_i (TURN_LD),
        .dec_i      (turn_dec),
        .zero_o     (turn_zero)
    );

    always_comb begin
        state_d   = state_q;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rd) begin
                    state_d   = ST_RD_ACC;
                    wait_load = 1'b1;
                end else if (start_wr) begin
                    state_d = ST_WR_SETUP;
                end
            end
            ST_RD_ACC: begin
                if (wait_zero) state_d = ST_IDLE;
                else           wait_dec = 1'b1;
            end
            ST_WR_SETUP: begin
                state_d   = ST_WR_ACC;
                wait_load = 1'b1;
            end
            ST_WR_ACC: begin
                if (wait_zero) state_d = ST_WR_HOLD;
                else           wait_dec = 1'b1;
            end
            ST_WR_HOLD: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        turn_load = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        turn_dec  = (state_q == ST_IDLE);
        last_we_d = turn_load ? (state_q == ST_WR_HOLD) : last_we_q;

        cs_n_d  = (state_d == ST_IDLE);
        oe_n_d  = (state_d != ST_RD_ACC);
        we_n_d  = (state_d != ST_WR_ACC);
        dq_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_ACC) || (state_d == ST_WR_HOLD);

        be_n_d = be_n_q;
        if (start_rd)                be_n_d = '0;
        else if (start_wr)           be_n_d = ~req_be_i;
        else if (state_d == ST_IDLE) be_n_d = '1;

        addr_d = (start_rd || start_wr) ? req_addr_i : addr_q;
        dq_d   = start_wr ? req_wdata_i : dq_q;

        // Read data is sampled on the edge that closes the last access cycle.
        rsp_valid_d = (state_q == ST_RD_ACC) && wait_zero;
        rdata_d     = rsp_valid_d ? sram_dq_i : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_we_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            be_n_q      <= '1;
            addr_q      <= '0;
            dq_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_we_q   <= last_we_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            be_n_q      <= be_n_d;
            addr_q      <= addr_d;
            dq_q        <= dq_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE) || !turn_zero;
    assign sram_cs_no   = cs_n_q;
    assign sram_we_no   = we_n_q;
    assign sram_oe_no   = oe_n_q;
    assign sram_be_no   = be_n_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rdata_q;
    assign dbg_state_o  = state_q;

endmodule
